// File: rtl/pid_scheduler.sv
// Round-robin dispatcher sharing one PID core across N_CH channels, one request per enabled channel per round.
// Latency: 1 cycle from sample_tick to first request; 2 cycles minimum per channel (accept + done).
// Backpressure: holds pid_req/pid_ch until pid_ack; pid_abort ends a channel after TIMEOUT cycles without pid_done.
module pid_scheduler #(
  parameter int N_CH    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_tick,
  input  logic [N_CH-1:0]            ch_enable,
  output logic                       pid_req,
  output logic [$clog2(N_CH)-1:0]    pid_ch,
  input  logic                       pid_ack,
  input  logic                       pid_done,
  input  logic [W-1:0]               pid_result,
  output logic                       pid_abort,
  output logic [N_CH*W-1:0]          ch_out,
  output logic [N_CH-1:0]            ch_out_valid,
  output logic                       busy,
  output logic                       overrun,
  output logic [N_CH-1:0]            timeout_err,
  input  logic                       err_clr
);

  localparam int CW = $clog2(N_CH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [N_CH-1:0]           r_pending;
  logic [CW-1:0]             r_ch;
  logic [TW-1:0]             r_cnt;
  logic [N_CH-1:0][W-1:0]    r_ch_out;
  logic [N_CH-1:0]           r_valid;
  logic                      r_overrun;
  logic [N_CH-1:0]           r_terr;

  logic                      w_busy;
  logic                      w_tick_go;
  logic                      w_done;
  logic                      w_timeout;
  logic                      w_finish;
  logic [N_CH-1:0]           w_pend_left;
  logic [N_CH-1:0]           w_terr_set;

  // Lowest set bit of a channel mask; callers guarantee the mask is nonzero.
  function automatic logic [CW-1:0] f_lowest(input logic [N_CH-1:0] m);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  assign w_busy      = (r_state != S_IDLE);
  assign w_tick_go   = (r_state == S_IDLE) && sample_tick && (|ch_enable);
  assign w_done      = (r_state == S_WAIT) && pid_done;
  // A done on the final allowed cycle still counts as done, so it masks the timeout.
  assign w_timeout   = w_busy && (r_cnt == TW'(TIMEOUT - 1)) && !w_done;
  assign w_finish    = w_done || w_timeout;
  assign w_pend_left = r_pending & ~(N_CH'(1) << r_ch);
  assign w_terr_set  = w_timeout ? (N_CH'(1) << r_ch) : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    pid_req     = 1'b0;
    pid_abort   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick_go) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        pid_req = 1'b1;
        busy    = 1'b1;
        if (w_timeout) begin
          pid_abort   = 1'b1;
          w_state_nxt = (|w_pend_left) ? S_ISSUE : S_IDLE;
        end else if (pid_ack) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_finish) begin
          pid_abort   = w_timeout;
          w_state_nxt = (|w_pend_left) ? S_ISSUE : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Round bookkeeping: latched mask of channels still owed, current channel, per-channel cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_ch      <= '0;
      r_cnt     <= '0;
    end else if (w_tick_go) begin
      r_pending <= ch_enable;
      r_ch      <= f_lowest(ch_enable);
      r_cnt     <= '0;
    end else if (w_finish) begin
      r_pending <= w_pend_left;
      if (|w_pend_left) r_ch <= f_lowest(w_pend_left);
      r_cnt     <= '0;
    end else if (w_busy) begin
      r_cnt     <= r_cnt + TW'(1);
    end
  end

  // Result capture and single-cycle valid pulse for the channel that completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_out <= '0;
      r_valid  <= '0;
    end else begin
      r_valid <= '0;
      if (w_done) begin
        r_ch_out[r_ch] <= pid_result;
        r_valid[r_ch]  <= 1'b1;
      end
    end
  end

  // Sticky error flags; a new set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_terr    <= '0;
    end else begin
      if (sample_tick && w_busy) r_overrun <= 1'b1;
      else if (err_clr)          r_overrun <= 1'b0;
      r_terr <= (err_clr ? '0 : r_terr) | w_terr_set;
    end
  end

  assign pid_ch       = r_ch;
  assign ch_out       = r_ch_out;
  assign ch_out_valid = r_valid;
  assign overrun      = r_overrun;
  assign timeout_err  = r_terr;

endmodule

// File: tb/tb_pid_scheduler.sv
// Directed bench for pid_scheduler: instance a uses default TIMEOUT=64, instance b uses TIMEOUT=8.
// Both share stimulus; each step checks only the instance whose behaviour it targets.
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
module tb_pid_scheduler;

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic [3:0]  ch_enable;
  logic        pid_ack;
  logic        pid_done;
  logic [15:0] pid_result;
  logic        err_clr;

  logic        req_a, abort_a, busy_a, ovr_a;
  logic [1:0]  ch_a;
  logic [63:0] out_a;
  logic [3:0]  vld_a, terr_a;

  logic        req_b, abort_b, busy_b, ovr_b;
  logic [1:0]  ch_b;
  logic [63:0] out_b;
  logic [3:0]  vld_b, terr_b;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  pid_scheduler #(.N_CH(4), .W(16), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .ch_enable(ch_enable),
    .pid_req(req_a), .pid_ch(ch_a), .pid_ack(pid_ack), .pid_done(pid_done),
    .pid_result(pid_result), .pid_abort(abort_a), .ch_out(out_a), .ch_out_valid(vld_a),
    .busy(busy_a), .overrun(ovr_a), .timeout_err(terr_a), .err_clr(err_clr)
  );

  pid_scheduler #(.N_CH(4), .W(16), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .ch_enable(ch_enable),
    .pid_req(req_b), .pid_ch(ch_b), .pid_ack(pid_ack), .pid_done(pid_done),
    .pid_result(pid_result), .pid_abort(abort_b), .ch_out(out_b), .ch_out_valid(vld_b),
    .busy(busy_b), .overrun(ovr_b), .timeout_err(terr_b), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Serve one channel on instance a. Precondition: a is in its first ISSUE cycle for ch.
  task automatic serve(input int ch, input int ack_dly, input int done_dly,
                       input logic [15:0] res, input bit tk);
    chk("req_issue", 64'(req_a), 64'd1);
    chk("ch_issue", 64'(ch_a), 64'(ch));
    for (int i = 0; i < ack_dly; i++) begin
      cyc();
      chk("req_hold", 64'(req_a), 64'd1);
      chk("ch_hold", 64'(ch_a), 64'(ch));
    end
    pid_ack = 1'b1;
    cyc();
    pid_ack = 1'b0;
    chk("req_drop", 64'(req_a), 64'd0);
    for (int i = 0; i < done_dly; i++) cyc();
    pid_done    = 1'b1;
    pid_result  = res;
    sample_tick = tk;
    cyc();
    pid_done    = 1'b0;
    sample_tick = 1'b0;
    chk("vld_pulse", 64'(vld_a), 64'(4'b0001 << ch));
    chk("ch_out_slot", 64'(out_a[ch*16 +: 16]), 64'(res));
  endtask

  initial begin
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    ch_enable   = 4'b0000;
    pid_ack     = 1'b0;
    pid_done    = 1'b0;
    pid_result  = 16'h0000;
    err_clr     = 1'b0;

    // Reset values.
    #3;
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_req", 64'(req_a), 64'd0);
    chk("rst_ch", 64'(ch_a), 64'd0);
    chk("rst_abort", 64'(abort_a), 64'd0);
    chk("rst_out", out_a, 64'd0);
    chk("rst_vld", 64'(vld_a), 64'd0);
    chk("rst_ovr", 64'(ovr_a), 64'd0);
    chk("rst_terr", 64'(terr_a), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Tick with an empty mask is ignored.
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk("zero_mask_busy", 64'(busy_a), 64'd0);
    chk("zero_mask_ovr", 64'(ovr_a), 64'd0);

    // Round over 4'b1011; mid-round mask change and a stray tick must not disturb it.
    sample_tick = 1'b1;
    ch_enable   = 4'b1011;
    cyc();
    sample_tick = 1'b0;
    ch_enable   = 4'b1111;
    chk("round_busy", 64'(busy_a), 64'd1);
    serve(0, 0, 2, 16'h0100, 1'b0);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk("ovr_set", 64'(ovr_a), 64'd1);
    serve(1, 0, 2, 16'h0101, 1'b0);
    serve(3, 0, 2, 16'h0103, 1'b0);
    chk("round_end_busy", 64'(busy_a), 64'd0);
    chk("round_out", out_a, 64'h0103_0000_0101_0100);
    chk("no_abort", 64'(terr_a), 64'd0);
    cyc();
    chk("vld_clear", 64'(vld_a), 64'd0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("ovr_clr", 64'(ovr_a), 64'd0);

    // Ack held off for 10 cycles; a tick on the edge back to IDLE is dropped.
    do_reset();
    sample_tick = 1'b1;
    ch_enable   = 4'b0001;
    cyc();
    sample_tick = 1'b0;
    serve(0, 10, 0, 16'h0055, 1'b1);
    chk("slow_busy", 64'(busy_a), 64'd0);
    chk("idle_edge_ovr", 64'(ovr_a), 64'd1);
    cyc();
    chk("dropped_tick", 64'(busy_a), 64'd0);

    // Timeout on channel 1 of instance b.
    do_reset();
    sample_tick = 1'b1;
    ch_enable   = 4'b0111;
    cyc();
    sample_tick = 1'b0;
    pid_ack = 1'b1;
    cyc();
    pid_ack    = 1'b0;
    pid_done   = 1'b1;
    pid_result = 16'h0200;
    cyc();
    pid_done = 1'b0;
    chk("b_ch0_out", 64'(out_b[15:0]), 64'h0200);
    chk("b_ch1_issue", 64'(ch_b), 64'd1);
    pid_ack = 1'b1;
    cyc();
    pid_ack = 1'b0;
    repeat (5) cyc();
    chk("b_abort_c7", 64'(abort_b), 64'd0);
    cyc();
    chk("b_abort_c8", 64'(abort_b), 64'd1);
    chk("b_terr_pre", 64'(terr_b), 64'd0);
    cyc();
    chk("b_abort_gone", 64'(abort_b), 64'd0);
    chk("b_terr", 64'(terr_b), 64'b0010);
    chk("b_ch2_issue", 64'(ch_b), 64'd2);
    chk("b_ch2_req", 64'(req_b), 64'd1);
    chk("b_slot1_kept", 64'(out_b[31:16]), 64'd0);
    chk("b_no_vld", 64'(vld_b), 64'd0);
    pid_ack = 1'b1;
    cyc();
    pid_ack    = 1'b0;
    pid_done   = 1'b1;
    pid_result = 16'h0202;
    cyc();
    pid_done = 1'b0;
    chk("b_ch2_out", 64'(out_b[47:32]), 64'h0202);
    chk("b_ch2_vld", 64'(vld_b), 64'b0100);
    chk("b_round_end", 64'(busy_b), 64'd0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("b_terr_clr", 64'(terr_b), 64'd0);

    // Done arriving on the timeout cycle counts as done.
    do_reset();
    sample_tick = 1'b1;
    ch_enable   = 4'b0001;
    cyc();
    sample_tick = 1'b0;
    pid_ack = 1'b1;
    cyc();
    pid_ack = 1'b0;
    repeat (6) cyc();
    pid_done   = 1'b1;
    pid_result = 16'h03C3;
    #1;
    chk("b_edge_abort", 64'(abort_b), 64'd0);
    cyc();
    pid_done = 1'b0;
    chk("b_edge_out", 64'(out_b[15:0]), 64'h03C3);
    chk("b_edge_vld", 64'(vld_b), 64'b0001);
    chk("b_edge_terr", 64'(terr_b), 64'd0);
    chk("b_edge_busy", 64'(busy_b), 64'd0);

    // Reset asserted while instance a waits on channel 2.
    do_reset();
    sample_tick = 1'b1;
    ch_enable   = 4'b0111;
    cyc();
    sample_tick = 1'b0;
    serve(0, 0, 0, 16'h0A0A, 1'b0);
    serve(1, 0, 0, 16'h0B0B, 1'b0);
    pid_ack     = 1'b1;
    sample_tick = 1'b1;
    cyc();
    pid_ack     = 1'b0;
    sample_tick = 1'b0;
    chk("mid_wait_busy", 64'(busy_a), 64'd1);
    chk("mid_wait_ovr", 64'(ovr_a), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_a), 64'd0);
    chk("arst_req", 64'(req_a), 64'd0);
    chk("arst_ch", 64'(ch_a), 64'd0);
    chk("arst_out", out_a, 64'd0);
    chk("arst_vld", 64'(vld_a), 64'd0);
    chk("arst_ovr", 64'(ovr_a), 64'd0);
    cyc();
    rst_n      = 1'b1;
    pid_done   = 1'b1;
    pid_result = 16'hDEAD;
    cyc();
    pid_done = 1'b0;
    chk("late_done_out", out_a, 64'd0);
    chk("late_done_vld", 64'(vld_a), 64'd0);
    chk("late_done_busy", 64'(busy_a), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pid_scheduler.md
PID_SCHEDULER -- requirements
Module: pid_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of PID channels sharing one PID core (2..16).
REQ-002 SHALL have parameter W, default 16, signed two's-complement result width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles per channel from first pid_req to pid_done (>=4).
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sample_tick  in  1  one-cycle pulse starting a control round.
REQ-007 SHALL have port ch_enable  in  N_CH  per-channel enable, latched at round start.
REQ-008 SHALL have port pid_req  out  1  request to the PID core to compute channel pid_ch.
REQ-009 SHALL have port pid_ch  out  clog2(N_CH)  channel index presented with pid_req.
REQ-010 SHALL have port pid_ack  in  1  core accepts request when pid_req&pid_ack.
REQ-011 SHALL have port pid_done  in  1  one-cycle pulse, pid_result valid.
REQ-012 SHALL have port pid_result  in  W  core output for the accepted channel.
REQ-013 SHALL have port pid_abort  out  1  one-cycle pulse cancelling the in-flight channel on timeout.
REQ-014 SHALL have port ch_out  out  N_CH*W  registered per-channel outputs, channel c at bits [c*W +: W].
REQ-015 SHALL have port ch_out_valid  out  N_CH  one-cycle pulse per channel on ch_out update.
REQ-016 SHALL have ports busy (out 1, round in progress), overrun (out 1, sticky), timeout_err (out N_CH, sticky), err_clr (in 1, clears sticky flags).

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> (ISSUE | IDLE); busy=1 in ISSUE and WAIT only.
REQ-018 In IDLE, sample_tick with nonzero ch_enable SHALL latch the mask, enter ISSUE next cycle on the lowest enabled index; zero mask: tick ignored, no flags.
REQ-019 Channels SHALL be serviced in ascending index order, each latched-enabled channel exactly once per round; ch_enable changes mid-round have no effect.
REQ-020 In ISSUE, pid_req SHALL be 1 with pid_ch stable until the edge where pid_ack=1, then go to WAIT with pid_req=0 from the next cycle.
REQ-021 pid_req SHALL be 0 outside ISSUE; pid_ack outside ISSUE SHALL be ignored.
REQ-022 In WAIT, pid_done SHALL cause ch_out[c]<=pid_result and ch_out_valid[c]=1 for exactly the next cycle, then advance to next enabled channel (ISSUE) or IDLE if none.
REQ-023 pid_done outside WAIT SHALL be ignored (no output change).
REQ-024 A per-channel counter SHALL clear on entering ISSUE and increment each ISSUE/WAIT cycle; on reaching TIMEOUT without pid_done: pid_abort pulse 1 cycle, timeout_err[c]<=1, ch_out[c] unchanged, advance as REQ-022.
REQ-025 pid_done on the same edge the counter reaches TIMEOUT SHALL count as done; no abort, no error.
REQ-026 sample_tick when state is not IDLE (including the edge returning to IDLE) SHALL be dropped and set overrun=1.
REQ-027 err_clr SHALL clear overrun and timeout_err next cycle; a simultaneous set event SHALL win over clear.
REQ-028 Minimum round time SHALL be 1 + 2 cycles per channel (ack and done each arriving one cycle after request/acceptance).

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, pid_req=0, pid_ch=0, pid_abort=0, busy=0, ch_out=0, ch_out_valid=0, overrun=0, timeout_err=0, counter=0.
REQ-030 Reset mid-round SHALL abandon the round; first round after release requires a new sample_tick.

Verification
REQ-031 Tick, ch_enable=4'b1011, core acks immediately, done 3 cycles later with 0x0100+c -> pid_ch sequence 0,1,3; ch_out slots 0,1,3 = 0x0100,0x0101,0x0103, slot 2 = 0; three valid pulses; busy drops after channel 3.
REQ-032 ch_enable=4'b0001, pid_ack held 0 for 10 cycles then 1 -> pid_req/pid_ch=0 stable for 11 cycles, one request accepted.
REQ-033 TIMEOUT=8, channel 1 never returns done -> pid_abort at cycle 8 of channel 1, timeout_err=4'b0010, ch_out slot 1 unchanged, channel 2 then serviced.
REQ-034 Second sample_tick while busy=1 -> overrun=1, round unaffected; err_clr pulse in IDLE -> overrun=0 next cycle.
REQ-035 rst_n asserted in WAIT of channel 2 -> all outputs at reset values immediately; late pid_done after release ignored.
REQ-036 pid_done coincident with timeout edge (TIMEOUT=8) -> ch_out updated, no abort, timeout_err stays 0.
